// File: rtl/division_result_display_pkg.sv
// Shared types, segment patterns and the double-dabble step
// for the divider result display.
package division_leds_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam int ITER_COUNT = 8;

  // Active-low cathodes, bit 0 = a .. bit 6 = g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_Q     = 7'b0011000;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  function automatic logic [6:0] seg_of(
    input logic [3:0] n
  );
    logic [6:0] s;
    case (n)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // {hund[1:0], tens, ones, bin[7:0]}; hundreds never reaches 5
  function automatic logic [17:0] dd_step(
    input logic [17:0] x
  );
    logic [17:0] a;
    a = x;
    if (a[11:8] >= 4'd5)
      a[11:8] = a[11:8] + 4'd3;
    if (a[15:12] >= 4'd5)
      a[15:12] = a[15:12] + 4'd3;
    return {a[16:0], 1'b0};
  endfunction

endpackage

// File: rtl/division_result_display_if.sv
// Divider-to-display result handshake bundle.
interface division_result_display_if;

  logic       done;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       busy;
  logic       result_valid;

  modport master (
    output done,
    output Quotient,
    output Remainder,
    input  busy,
    input  result_valid
  );

  modport slave (
    input  done,
    input  Quotient,
    input  Remainder,
    output busy,
    output result_valid
  );

endinterface

// File: rtl/division_result_display_seven_seg_mux.sv
// Refresh counter, digit scan and registered seg/an
// outputs for the 4-digit multiplexed display.
module seven_seg_mux
  import division_leds_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       no_result,
  input  logic       sel_rem,
  input  logic [9:0] bcd_quo,
  input  logic [9:0] bcd_rem,
  output logic [6:0] seg,
  output logic [3:0] an
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic [9:0]       val;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(REFRESH_CYCLES - 1));
  assign val  = sel_rem ? bcd_rem : bcd_quo;

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    an_d  = ~(4'b0001 << idx_d);
    seg_d = SEG_DASH;
    if (!no_result) begin
      unique case (idx_d)
        2'd3: seg_d = sel_rem ? SEG_R : SEG_Q;
        2'd2: seg_d = (val[9:8] == 2'd0) ? SEG_BLANK
                    : seg_of({2'b00, val[9:8]});
        2'd1: seg_d = (val[9:4] == 6'd0) ? SEG_BLANK
                    : seg_of(val[7:4]);
        2'd0: seg_d = seg_of(val[3:0]);
      endcase
    end
  end

  // seg and an share one register stage so they switch together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      seg_q <= SEG_DASH;
      an_q  <= 4'b1110;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: rtl/division_result_display.sv
// Captures divider results on done rise, converts them to BCD
// by sequential double-dabble and drives the 7-segment mux.
module division_result_display
  import division_leds_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic                       sys_clock,
  input  logic                       reset_n,
  division_result_display_if.slave   div,
  input  logic                       sel_rem,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [3:0]                 an
);

  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic        arm_q, arm_d;
  logic        pend_q, pend_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        nores_q, nores_d;
  logic [2:0]  iter_q, iter_d;
  logic [17:0] quo_sh_q, quo_sh_d;
  logic [17:0] rem_sh_q, rem_sh_d;
  logic [9:0]  quo_disp_q, quo_disp_d;
  logic [9:0]  rem_disp_q, rem_disp_d;
  logic [17:0] quo_step, rem_step;
  logic        rise, load;

  // arm blocks a done held high across reset release
  assign rise     = div.done & ~done_q & arm_q;
  assign quo_step = dd_step(quo_sh_q);
  assign rem_step = dd_step(rem_sh_q);

  always_comb begin
    state_d    = state_q;
    done_d     = div.done;
    arm_d      = arm_q | ~div.done;
    pend_d     = pend_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    nores_d    = nores_q;
    iter_d     = iter_q;
    quo_sh_d   = quo_sh_q;
    rem_sh_d   = rem_sh_q;
    quo_disp_d = quo_disp_q;
    rem_disp_d = rem_disp_q;
    load       = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): load = rise;
      (state_q == CONVERT): begin
        quo_sh_d = quo_step;
        rem_sh_d = rem_step;
        iter_d   = iter_q + 3'd1;
        if (rise)
          pend_d = 1'b1;
        if (iter_q == 3'(ITER_COUNT - 1)) begin
          quo_disp_d = quo_step[17:8];
          rem_disp_d = rem_step[17:8];
          nores_d    = 1'b0;
          valid_d    = 1'b1;
          if (pend_q | rise) begin
            load   = 1'b1;
            pend_d = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
    endcase
    if (load) begin
      quo_sh_d = {10'd0, div.Quotient};
      rem_sh_d = {10'd0, div.Remainder};
      iter_d   = 3'd0;
      busy_d   = 1'b1;
      state_d  = CONVERT;
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      arm_q      <= 1'b0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      nores_q    <= 1'b1;
      iter_q     <= 3'd0;
      quo_sh_q   <= '0;
      rem_sh_q   <= '0;
      quo_disp_q <= '0;
      rem_disp_q <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      arm_q      <= arm_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      nores_q    <= nores_d;
      iter_q     <= iter_d;
      quo_sh_q   <= quo_sh_d;
      rem_sh_q   <= rem_sh_d;
      quo_disp_q <= quo_disp_d;
      rem_disp_q <= rem_disp_d;
    end
  end

  assign div.busy         = busy_q;
  assign div.result_valid = valid_q;
  assign dp               = 1'b1;

  seven_seg_mux #(
    .REFRESH_CYCLES (REFRESH_CYCLES),
    .CNT_W          (CNT_W)
  ) u_mux (
    .clk       (sys_clock),
    .rst_n     (reset_n),
    .no_result (nores_q),
    .sel_rem   (sel_rem),
    .bcd_quo   (quo_disp_q),
    .bcd_rem   (rem_disp_q),
    .seg       (seg),
    .an        (an)
  );

endmodule
